// File: rtl/ser_word_asm.sv
// ser_word_asm: packs a qualified serial bit stream into WIDTH-bit words and
// presents each word through a one-entry holding register with valid/ready.
//
// Ports:
//   i_clk          rising-edge clock
//   i_reset        synchronous active-high reset
//   i_si           serial data bit
//   i_si_valid     i_si is meaningful this cycle
//   i_msb_first    bit order, sampled with the first bit of each word
//   o_word         holding-register contents
//   o_word_valid   holding register occupied
//   i_word_ready   consumer accepts o_word this cycle
//   o_bitcnt       bits accumulated in the shift register (0..WIDTH)
//   o_busy         o_bitcnt != 0
//   o_overrun      sticky flag: a valid bit was dropped
//   i_clr_ovr      synchronous clear of o_overrun (a new drop wins)
module ser_word_asm #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_si,
  input  logic             i_si_valid,
  input  logic             i_msb_first,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [CW-1:0]    o_bitcnt,
  output logic             o_busy,
  output logic             o_overrun,
  input  logic             i_clr_ovr
);

  // State is fully implied by the bit counter; decoded here for readability.
  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFull
  } state_e;

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_bitcnt;
  logic             r_ord;
  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sr_nxt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic             w_ord_nxt;
  logic [WIDTH-1:0] w_word_nxt;
  logic             w_word_valid_nxt;
  logic             w_overrun_nxt;

  state_e           w_state;
  logic             w_ord_eff;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_single;
  logic             w_handshake;
  logic             w_free;
  logic             w_load;
  logic             w_drop;

  always_comb begin
    if (r_bitcnt == '0) begin
      w_state = StIdle;
    end else if (r_bitcnt == CW'(WIDTH)) begin
      w_state = StFull;
    end else begin
      w_state = StShift;
    end
  end

  // The order bit only follows i_msb_first on the first bit of a word.
  assign w_ord_eff   = (w_state == StIdle) ? i_msb_first : r_ord;
  assign w_shifted   = w_ord_eff ? {r_sr[WIDTH-2:0], i_si} : {i_si, r_sr[WIDTH-1:1]};
  // First bit of a new word when the shift register was reloaded from FULL.
  assign w_single    = i_msb_first ? {{(WIDTH-1){1'b0}}, i_si} : {i_si, {(WIDTH-1){1'b0}}};
  assign w_handshake = r_word_valid & i_word_ready;
  assign w_free      = ~r_word_valid | i_word_ready;

  always_comb begin
    w_sr_nxt         = r_sr;
    w_bitcnt_nxt     = r_bitcnt;
    w_ord_nxt        = r_ord;
    w_word_nxt       = r_word;
    w_word_valid_nxt = r_word_valid;
    w_overrun_nxt    = r_overrun;
    w_load           = 1'b0;
    w_drop           = 1'b0;

    unique case (w_state)
      StIdle, StShift: begin
        if (i_si_valid) begin
          w_ord_nxt = w_ord_eff;
          w_sr_nxt  = w_shifted;
          if (r_bitcnt == CW'(WIDTH - 1)) begin
            if (w_free) begin
              w_word_nxt   = w_shifted;
              w_load       = 1'b1;
              w_bitcnt_nxt = '0;
            end else begin
              w_bitcnt_nxt = CW'(WIDTH);
            end
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
      StFull: begin
        if (w_handshake) begin
          w_word_nxt   = r_sr;
          w_load       = 1'b1;
          w_bitcnt_nxt = '0;
          if (i_si_valid) begin
            w_ord_nxt    = i_msb_first;
            w_sr_nxt     = w_single;
            w_bitcnt_nxt = CW'(1);
          end
        end else if (i_si_valid) begin
          w_drop = 1'b1;
        end
      end
      default: ;
    endcase

    // A word moving into the holding register keeps it occupied.
    if (w_load) begin
      w_word_valid_nxt = 1'b1;
    end else if (w_handshake) begin
      w_word_valid_nxt = 1'b0;
    end

    if (w_drop) begin
      w_overrun_nxt = 1'b1;
    end else if (i_clr_ovr) begin
      w_overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sr         <= '0;
      r_bitcnt     <= '0;
      r_ord        <= 1'b1;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sr         <= w_sr_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_ord        <= w_ord_nxt;
      r_word       <= w_word_nxt;
      r_word_valid <= w_word_valid_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_bitcnt     = r_bitcnt;
  assign o_busy       = (r_bitcnt != '0);
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_ser_word_asm.sv
// Bench for ser_word_asm: directed stimulus, a bit-position model of the
// assembler checked on every cycle, plus literal expectations at key points.
module tb_ser_word_asm;
  localparam int unsigned W   = 32;
  localparam int unsigned CWB = $clog2(W + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           si = 1'b0;
  logic           si_valid = 1'b0;
  logic           msb_first = 1'b1;
  logic           word_ready = 1'b0;
  logic           clr_ovr = 1'b0;
  logic [W-1:0]   word;
  logic           word_valid;
  logic [CWB-1:0] bitcnt;
  logic           busy;
  logic           overrun;

  always #5 clk = ~clk;

  ser_word_asm #(
    .WIDTH(W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_si        (si),
    .i_si_valid  (si_valid),
    .i_msb_first (msb_first),
    .o_word      (word),
    .o_word_valid(word_valid),
    .i_word_ready(word_ready),
    .o_bitcnt    (bitcnt),
    .o_busy      (busy),
    .o_overrun   (overrun),
    .i_clr_ovr   (clr_ovr)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model: bits are placed by arrival index; no shifting is modelled.
  int          m_cnt  = 0;
  logic [31:0] m_acc  = '0;
  logic [31:0] m_word = '0;
  bit          m_ord  = 1'b1;
  bit          m_wv   = 1'b0;
  bit          m_ovr  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic b, input logic v, input logic msb, input logic rdy,
                            input logic clr, input logic r);
    bit hs, xfer, drop;
    int pos;
    if (r) begin
      m_cnt = 0; m_acc = '0; m_word = '0; m_ord = 1'b1; m_wv = 1'b0; m_ovr = 1'b0;
      return;
    end
    hs   = m_wv && rdy;
    xfer = 1'b0;
    drop = 1'b0;
    if (m_cnt == W) begin
      if (hs) begin
        m_word = m_acc; xfer = 1'b1; m_cnt = 0;
        if (v) begin
          m_ord = msb; m_acc = '0;
          pos = m_ord ? W - 1 : 0;
          m_acc[pos] = b; m_cnt = 1;
        end
      end else if (v) begin
        drop = 1'b1;
      end
    end else if (v) begin
      if (m_cnt == 0) begin
        m_ord = msb; m_acc = '0;
      end
      pos = m_ord ? W - 1 - m_cnt : m_cnt;
      m_acc[pos] = b;
      m_cnt++;
      if (m_cnt == W && (!m_wv || hs)) begin
        m_word = m_acc; xfer = 1'b1; m_cnt = 0;
      end
    end
    if (xfer) m_wv = 1'b1;
    else if (hs) m_wv = 1'b0;
    if (clr) m_ovr = 1'b0;
    if (drop) m_ovr = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("word", 64'(word), 64'(m_word));
      chk("word_valid", 64'(word_valid), 64'(m_wv));
      chk("bitcnt", 64'(bitcnt), 64'(m_cnt));
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("overrun", 64'(overrun), 64'(m_ovr));
    end
  end

  // One clock: drive inputs after the falling edge, update model after rising edge.
  task automatic cyc(input logic b, input logic v, input logic msb, input logic rdy,
                     input logic clr, input logic r);
    @(negedge clk);
    si = b; si_valid = v; msb_first = msb; word_ready = rdy; clr_ovr = clr; rst = r;
    @(posedge clk);
    #1;
    model_step(b, v, msb, rdy, clr, r);
  endtask

  task automatic send_word(input logic [31:0] w, input logic msb, input logic rdy,
                           input bit gaps, input bit toggle);
    int g;
    logic b, m;
    for (int i = 0; i < 32; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) cyc(1'b0, 1'b0, ~msb, rdy, 1'b0, 1'b0);
      b = msb ? w[31-i] : w[i];
      m = (toggle && i > 0) ? ~msb : msb;
      cyc(b, 1'b1, m, rdy, 1'b0, 1'b0);
    end
  endtask

  logic [31:0] wv;

  initial begin
    // Reset, with live data that must be ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_word", 64'(word), 64'h0);
    chk("rst_valid", 64'(word_valid), 64'h0);
    chk("rst_bitcnt", 64'(bitcnt), 64'h0);
    chk("rst_ovr", 64'(overrun), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // MSB-first, consumer always ready.
    send_word(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("msb_word", 64'(word), 64'hDEAD_BEEF);
    chk("msb_valid", 64'(word_valid), 64'h1);
    chk("msb_bitcnt", 64'(bitcnt), 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("msb_valid_1cyc", 64'(word_valid), 64'h0);

    // LSB-first, order input toggled after the first bit.
    send_word(32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("lsb_word", 64'(word), 64'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Gapped input: partial count must hold through idle cycles.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_hold", 64'(bitcnt), 64'd5);
    wv = 32'hF800_0000 | 32'h0123_4567;
    for (int i = 5; i < 32; i++) begin
      if ($urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(wv[31-i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("gap_word", 64'(word), 64'hF923_4567);
    send_word(32'hA5C3_0F96, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("gap_word2", 64'(word), 64'hA5C3_0F96);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Backpressure: two words with the consumer stalled.
    send_word(32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
    send_word(32'h9ABC_DEF0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_word", 64'(word), 64'h1234_5678);
    chk("bp_bitcnt", 64'(bitcnt), 64'd32);
    chk("bp_ovr0", 64'(overrun), 64'h0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("bp_ovr1", 64'(overrun), 64'h1);
    chk("bp_word_kept", 64'(word), 64'h1234_5678);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("bp_word2", 64'(word), 64'h9ABC_DEF0);
    chk("bp_valid2", 64'(word_valid), 64'h1);
    chk("bp_bitcnt1", 64'(bitcnt), 64'd1);

    // Overrun clear vs. set priority.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr", 64'(overrun), 64'h0);
    wv = 32'hC3C3_C3C3;
    for (int i = 1; i < 32; i++) cyc(wv[31-i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_full", 64'(bitcnt), 64'd32);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ovr_set_wins", 64'(overrun), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("ovr_clr_alone", 64'(overrun), 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("drain_word", 64'(word), 64'hC3C3_C3C3);
    chk("drain_valid", 64'(word_valid), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 64'(word_valid), 64'h0);

    // Reset mid-word, after leaving a word and an overrun behind.
    send_word(32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 1'b0);
    wv = 32'hFFFF_FFFF;
    for (int i = 0; i < 17; i++) cyc(wv[i], 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("mid_bitcnt", 64'(bitcnt), 64'd17);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_bitcnt", 64'(bitcnt), 64'h0);
    chk("mid_rst_word", 64'(word), 64'h0);
    chk("mid_rst_valid", 64'(word_valid), 64'h0);
    chk("mid_rst_ovr", 64'(overrun), 64'h0);
    send_word(32'h0F1E_2D3C, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_word", 64'(word), 64'h0F1E_2D3C);
    chk("post_rst_valid", 64'(word_valid), 64'h1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
